// File: rtl/capture_pkg.sv
// capture_pkg: shared definitions for the capture controller.
//   state_e        - controller / transmit-handshake state encoding
//   CMD_*          - one-byte command codes received over the UART
//   ST_BIT_*       - bit positions inside the status byte
//   status_byte()  - assembles the status byte from its four flags
package capture_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    CAPTURE,
    RD_REQ,
    RD_WAIT,
    TX_GO,
    TX_ARM,
    TX_WAIT,
    ST_SEND
  } state_e;

  localparam logic [7:0] CMD_CAPTURE = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] CMD_STATUS  = 8'h03;
  localparam logic [7:0] CMD_ABORT   = 8'h04;

  localparam int ST_BIT_OVERFLOW = 7;
  localparam int ST_BIT_FULL     = 6;
  localparam int ST_BIT_EMPTY    = 5;
  localparam int ST_BIT_DONE     = 4;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty, input logic done);
    logic [7:0] s;
    s                  = 8'h00;
    s[ST_BIT_OVERFLOW] = ovf;
    s[ST_BIT_FULL]     = full;
    s[ST_BIT_EMPTY]    = empty;
    s[ST_BIT_DONE]     = done;
    return s;
  endfunction

endpackage

// File: rtl/capture_ctrl_tx_handshake.sv
// tx_handshake: hands one byte to the UART transmitter.
//   clk, reset   - clock, synchronous active-high reset
//   load_i       - strobe: latch byte_i and start a transfer (ignored unless idle)
//   byte_i       - byte to send
//   abort_i      - drop the transfer in progress, back to idle next cycle
//   tx_busy_i    - transmitter busy
//   tx_start_o   - one-cycle start request (registered)
//   tx_data_o    - latched byte (registered)
//   done_o       - one-cycle pulse once the transmitter has finished the byte
module tx_handshake
  import capture_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              abort_i,
  input  logic              tx_busy_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              done_o
);

  state_e            phase_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort_i) begin
        phase_q <= IDLE;
      end else begin
        case (phase_q)
          IDLE: if (load_i) begin
            // start is raised together with the data so it is high during TX_GO
            tx_data_q  <= byte_i;
            tx_start_q <= 1'b1;
            phase_q    <= TX_GO;
          end
          TX_GO:   phase_q <= TX_ARM;
          TX_ARM:  if (tx_busy_i) phase_q <= TX_WAIT;
          TX_WAIT: if (!tx_busy_i) begin
            phase_q <= IDLE;
            done_q  <= 1'b1;
          end
          default: phase_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign done_o     = done_q;

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: command sequencer between UART, camera stream and pixel FIFO.
//   clk, reset                      - clock, synchronous active-high reset
//   rx_data/rx_valid                - received command byte + strobe
//   cam_vsync/href/valid/data       - synchronised camera stream
//   fifo_full/empty/rdata           - FIFO status and read data (1-cycle latency)
//   fifo_we/wdata/re                - FIFO write / read controls (registered)
//   tx_data/tx_start/tx_busy        - UART transmitter handshake
//   busy                            - controller not in IDLE
//   overflow                        - sticky: a pixel was dropped because the FIFO was full
//   byte_count                      - bytes written by the last or current capture (saturating)
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_re,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  byte_count
);

  state_e            state_q;
  logic              vsync_q;
  logic              fifo_we_q;
  logic [DATA_W-1:0] fifo_wdata_q;
  logic              fifo_re_q;
  logic              busy_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  byte_count_q;
  logic              capture_done_q;
  logic              from_read_q;   // current transfer came from the FIFO, so keep draining

  logic              vsync_rise;
  logic              abort_cmd;
  logic              pixel_strobe;
  logic              hs_load;
  logic              hs_done;
  logic [DATA_W-1:0] hs_byte;

  assign vsync_rise   = cam_vsync & ~vsync_q;
  assign abort_cmd    = rx_valid && (rx_data == DATA_W'(CMD_ABORT));
  assign pixel_strobe = cam_valid && cam_href;

  // The handshake is loaded straight from RD_WAIT (FIFO byte) or ST_SEND (status byte).
  assign hs_load = !abort_cmd && ((state_q == RD_WAIT) || (state_q == ST_SEND));
  assign hs_byte = (state_q == RD_WAIT) ? fifo_rdata :
                   DATA_W'(status_byte(overflow_q, fifo_full, fifo_empty, capture_done_q));

  tx_handshake #(.DATA_W(DATA_W)) u_tx_hs (
    .clk        (clk),
    .reset      (reset),
    .load_i     (hs_load),
    .byte_i     (hs_byte),
    .abort_i    (abort_cmd),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .done_o     (hs_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      vsync_q        <= 1'b0;
      fifo_we_q      <= 1'b0;
      fifo_wdata_q   <= '0;
      fifo_re_q      <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      byte_count_q   <= '0;
      capture_done_q <= 1'b0;
      from_read_q    <= 1'b0;
    end else begin
      vsync_q   <= cam_vsync;
      fifo_we_q <= 1'b0;
      fifo_re_q <= 1'b0;
      if (abort_cmd) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (rx_valid) begin
            if (rx_data == DATA_W'(CMD_CAPTURE)) begin
              state_q        <= ARM;
              busy_q         <= 1'b1;
              overflow_q     <= 1'b0;
              byte_count_q   <= '0;
              capture_done_q <= 1'b0;
            end else if (rx_data == DATA_W'(CMD_READ) && !fifo_empty) begin
              // fifo_re is raised on entry so it is high exactly while in RD_REQ
              state_q   <= RD_REQ;
              busy_q    <= 1'b1;
              fifo_re_q <= 1'b1;
            end else if (rx_data == DATA_W'(CMD_STATUS)) begin
              state_q <= ST_SEND;
              busy_q  <= 1'b1;
            end
          end
          ARM: if (vsync_rise) state_q <= CAPTURE;
          CAPTURE: begin
            // a pixel coinciding with the closing vsync edge is still written
            if (pixel_strobe) begin
              if (!fifo_full) begin
                fifo_we_q    <= 1'b1;
                fifo_wdata_q <= cam_data;
                if (byte_count_q != {CNT_W{1'b1}}) byte_count_q <= byte_count_q + CNT_W'(1);
              end else begin
                overflow_q <= 1'b1;
              end
            end
            if (vsync_rise) begin
              state_q        <= IDLE;
              busy_q         <= 1'b0;
              capture_done_q <= 1'b1;
            end
          end
          RD_REQ:  state_q <= RD_WAIT;
          RD_WAIT: begin
            state_q     <= TX_GO;
            from_read_q <= 1'b1;
          end
          ST_SEND: begin
            state_q     <= TX_GO;
            from_read_q <= 1'b0;
          end
          // These three track the handshake's own phases on the same inputs.
          TX_GO:  state_q <= TX_ARM;
          TX_ARM: if (tx_busy) state_q <= TX_WAIT;
          TX_WAIT: if (hs_done) begin
            if (from_read_q && !fifo_empty) begin
              state_q   <= RD_REQ;
              fifo_re_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_we    = fifo_we_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_re    = fifo_re_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: self-checking bench for capture_ctrl with behavioural
// FIFO and UART-transmitter models and randomized capture/read traffic.
module tb_capture_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              cam_vsync = 1'b0;
  logic              cam_href = 1'b0;
  logic              cam_valid = 1'b0;
  logic [DATA_W-1:0] cam_data = '0;
  logic              fifo_full = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_rdata = '0;
  logic              tx_busy = 1'b0;
  logic              fifo_we;
  logic [DATA_W-1:0] fifo_wdata;
  logic              fifo_re;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              busy;
  logic              overflow;
  logic [CNT_W-1:0]  byte_count;

  int cmp_count  = 0;
  int fail_count = 0;

  capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_valid  (cam_valid),
    .cam_data   (cam_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .fifo_re    (fifo_re),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model: registered read, full at fifo_cap entries
  logic [7:0] fq[$];
  logic [7:0] wr_log[$];
  int fifo_cap = 64;
  int we_count = 0, re_count = 0, we_while_full = 0, re_while_empty = 0;

  always @(posedge clk) begin
    if (fifo_we === 1'b1) begin
      we_count++;
      wr_log.push_back(fifo_wdata);
      if (fifo_full) we_while_full++;
      else if (fq.size() < fifo_cap) fq.push_back(fifo_wdata);
    end
    if (fifo_re === 1'b1) begin
      re_count++;
      if (fifo_empty || fq.size() == 0) re_while_empty++;
      else fifo_rdata <= fq.pop_front();
    end
    fifo_full  <= (fq.size() >= fifo_cap);
    fifo_empty <= (fq.size() == 0);
  end

  // ---------------- UART transmitter model: busy rises after a delay, then holds
  logic [7:0] tx_log[$];
  int tx_phase = 0, tx_cnt = 0, tx_rise_fixed = -1;
  int start_count = 0, start_while_busy = 0;

  always @(posedge clk) begin
    if (tx_start === 1'b1) begin
      start_count++;
      tx_log.push_back(tx_data);
      if (tx_phase != 0 || tx_busy) start_while_busy++;
      $display("tx byte %02h", tx_data);
    end
    case (tx_phase)
      0: if (tx_start === 1'b1) begin
        tx_phase = 1;
        tx_cnt   = (tx_rise_fixed >= 0) ? tx_rise_fixed : int'($urandom_range(0, 3));
      end
      1: if (tx_cnt == 0) begin
        tx_busy <= 1'b1;
        tx_phase = 2;
        tx_cnt   = int'($urandom_range(1, 6));
      end else tx_cnt--;
      default: if (tx_cnt == 0) begin
        tx_busy <= 1'b0;
        tx_phase = 0;
      end else tx_cnt--;
    endcase
  end

  // ---------------- stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    $display("cmd %02h sent", b);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    cam_vsync = 1'b1;
    tick(2);
    cam_vsync = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b, input logic href);
    @(negedge clk);
    cam_href  = href;
    cam_valid = 1'b1;
    cam_data  = b;
    @(negedge clk);
    cam_valid = 1'b0;
  endtask

  task automatic strobe_with_vsync(input logic [7:0] b);
    @(negedge clk);
    cam_href  = 1'b1;
    cam_valid = 1'b1;
    cam_data  = b;
    cam_vsync = 1'b1;
    @(negedge clk);
    cam_valid = 1'b0;
    @(negedge clk);
    cam_vsync = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx_quiet();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_phase == 0 && !tx_busy) break;
    end
  endtask

  task automatic clear_fifo(input int cap);
    @(negedge clk);
    fq.delete();
    fifo_cap = cap;
    tick(2);
  endtask

  // ---------------- tests
  task automatic test_reset();
    int  re0;
    bit  busy_seen;
    reset = 1'b1;
    tick(5);
    cmp_count += 8;
    if (fifo_we !== 1'b0)     begin fail_count++; $display("FAIL reset_fifo_we got %b want 0", fifo_we); end
    if (fifo_re !== 1'b0)     begin fail_count++; $display("FAIL reset_fifo_re got %b want 0", fifo_re); end
    if (tx_start !== 1'b0)    begin fail_count++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    if (busy !== 1'b0)        begin fail_count++; $display("FAIL reset_busy got %b want 0", busy); end
    if (overflow !== 1'b0)    begin fail_count++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (byte_count !== '0)    begin fail_count++; $display("FAIL reset_byte_count got %0d want 0", byte_count); end
    if (tx_data !== '0)       begin fail_count++; $display("FAIL reset_tx_data got %02h want 00", tx_data); end
    if (fifo_wdata !== '0)    begin fail_count++; $display("FAIL reset_fifo_wdata got %02h want 00", fifo_wdata); end
    reset = 1'b0;
    tick(2);
    // read request on an empty FIFO must be ignored
    re0 = re_count;
    send_cmd(8'h02);
    busy_seen = (busy !== 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    cmp_count += 2;
    if (re_count != re0) begin fail_count++; $display("FAIL empty_read_re got %0d pulses want 0", re_count - re0); end
    if (busy_seen)       begin fail_count++; $display("FAIL empty_read_busy got 1 want 0"); end
  endtask

  task automatic test_capture();
    int we0, wr0;
    logic [7:0] expb;
    clear_fifo(64);
    we0 = we_count;
    wr0 = wr_log.size();
    send_cmd(8'h01);
    tick(1);
    vsync_pulse();
    for (int i = 0; i < 6; i++) strobe(8'hA0 + 8'(i), 1'b1);
    tick(2);
    cmp_count++;
    if (busy !== 1'b1) begin fail_count++; $display("FAIL capture_busy_mid got %b want 1", busy); end
    vsync_pulse();
    tick(2);
    cmp_count += 4;
    if (we_count - we0 != 6) begin fail_count++; $display("FAIL capture_we_pulses got %0d want 6", we_count - we0); end
    if (byte_count !== 16'd6) begin fail_count++; $display("FAIL capture_byte_count got %0d want 6", byte_count); end
    if (busy !== 1'b0) begin fail_count++; $display("FAIL capture_busy_end got %b want 0", busy); end
    if (overflow !== 1'b0) begin fail_count++; $display("FAIL capture_overflow got %b want 0", overflow); end
    for (int i = 0; i < 6 && wr0 + i < wr_log.size(); i++) begin
      expb = 8'hA0 + 8'(i);
      cmp_count++;
      if (wr_log[wr0 + i] !== expb) begin
        fail_count++;
        $display("FAIL capture_wdata[%0d] got %02h want %02h", i, wr_log[wr0 + i], expb);
      end
    end
  endtask

  task automatic test_overflow_status();
    int we0, wf0, tx0;
    bit ok;
    logic [7:0] sent[$];
    logic [7:0] b;
    clear_fifo(3);
    we0 = we_count;
    wf0 = we_while_full;
    send_cmd(8'h01);
    tick(1);
    vsync_pulse();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      strobe(b, 1'b1);
    end
    vsync_pulse();
    tick(2);
    cmp_count += 4;
    if (we_count - we0 != 3) begin fail_count++; $display("FAIL overflow_we_pulses got %0d want 3", we_count - we0); end
    if (we_while_full != wf0) begin fail_count++; $display("FAIL overflow_we_when_full got %0d want 0", we_while_full - wf0); end
    if (overflow !== 1'b1) begin fail_count++; $display("FAIL overflow_flag got %b want 1", overflow); end
    if (byte_count !== 16'd3) begin fail_count++; $display("FAIL overflow_byte_count got %0d want 3", byte_count); end
    // drain the three stored bytes, then ask for status
    tx0 = tx_log.size();
    send_cmd(8'h02);
    wait_idle(400, ok);
    cmp_count += 2;
    if (!ok) begin fail_count++; $display("FAIL drain_timeout got busy=%b want 0", busy); end
    if (tx_log.size() - tx0 != 3) begin fail_count++; $display("FAIL drain_count got %0d want 3", tx_log.size() - tx0); end
    for (int i = 0; i < 3 && tx0 + i < tx_log.size(); i++) begin
      cmp_count++;
      if (tx_log[tx0 + i] !== sent[i]) begin
        fail_count++;
        $display("FAIL drain_byte[%0d] got %02h want %02h", i, tx_log[tx0 + i], sent[i]);
      end
    end
    tx0 = tx_log.size();
    send_cmd(8'h03);
    wait_idle(100, ok);
    cmp_count++;
    if (!ok || tx_log.size() != tx0 + 1) begin
      fail_count++;
      $display("FAIL status_sent got %0d bytes want 1", tx_log.size() - tx0);
    end else begin
      cmp_count++;
      if (tx_log[tx0] !== 8'b1011_0000) begin
        fail_count++;
        $display("FAIL status_byte got %02h want b0", tx_log[tx0]);
      end
    end
  endtask

  task automatic test_read();
    int re0, st0, tx0, sb0;
    bit ok;
    logic [7:0] exp_q[$];
    clear_fifo(64);
    exp_q = '{8'h11, 8'h22, 8'h33};
    @(negedge clk);
    fq = exp_q;
    tick(2);
    re0 = re_count; st0 = start_count; tx0 = tx_log.size(); sb0 = start_while_busy;
    send_cmd(8'h02);
    wait_idle(400, ok);
    cmp_count += 5;
    if (!ok) begin fail_count++; $display("FAIL read_timeout got busy=%b want 0", busy); end
    if (re_count - re0 != 3) begin fail_count++; $display("FAIL read_re_pulses got %0d want 3", re_count - re0); end
    if (start_count - st0 != 3) begin fail_count++; $display("FAIL read_tx_starts got %0d want 3", start_count - st0); end
    if (start_while_busy != sb0) begin fail_count++; $display("FAIL read_start_overlap got %0d want 0", start_while_busy - sb0); end
    if (fifo_empty !== 1'b1) begin fail_count++; $display("FAIL read_fifo_drained got empty=%b want 1", fifo_empty); end
    for (int i = 0; i < 3 && tx0 + i < tx_log.size(); i++) begin
      cmp_count++;
      if (tx_log[tx0 + i] !== exp_q[i]) begin
        fail_count++;
        $display("FAIL read_byte[%0d] got %02h want %02h", i, tx_log[tx0 + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    int re0, st0, we0;
    bit found;
    clear_fifo(64);
    @(negedge clk);
    for (int i = 0; i < 3; i++) fq.push_back(8'($urandom));
    tx_rise_fixed = 15;
    tick(2);
    re0 = re_count; st0 = start_count;
    send_cmd(8'h02);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_start === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    cmp_count++;
    if (!found) begin fail_count++; $display("FAIL abort_setup_start got none want 1"); end
    // next cycle the controller is waiting for tx_busy to rise
    send_cmd(8'h04);
    cmp_count++;
    if (busy !== 1'b0) begin fail_count++; $display("FAIL abort_busy got %b want 0", busy); end
    tick(40);
    cmp_count += 3;
    if (start_count - st0 != 1) begin fail_count++; $display("FAIL abort_tx_starts got %0d want 1", start_count - st0); end
    if (re_count - re0 != 1) begin fail_count++; $display("FAIL abort_re_pulses got %0d want 1", re_count - re0); end
    if (fq.size() != 2) begin fail_count++; $display("FAIL abort_fifo_kept got %0d want 2", fq.size()); end
    wait_tx_quiet();
    tx_rise_fixed = -1;
    // a capture command during CAPTURE must not restart the count
    clear_fifo(64);
    we0 = we_count;
    send_cmd(8'h01);
    tick(1);
    vsync_pulse();
    for (int i = 0; i < 3; i++) strobe(8'($urandom), 1'b1);
    send_cmd(8'h01);
    cmp_count++;
    if (busy !== 1'b1) begin fail_count++; $display("FAIL ignore_cmd_busy got %b want 1", busy); end
    for (int i = 0; i < 3; i++) strobe(8'($urandom), 1'b1);
    vsync_pulse();
    tick(2);
    cmp_count += 2;
    if (byte_count !== 16'd6) begin fail_count++; $display("FAIL ignore_cmd_byte_count got %0d want 6", byte_count); end
    if (we_count - we0 != 6) begin fail_count++; $display("FAIL ignore_cmd_we got %0d want 6", we_count - we0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [7:0] exp_status;
    logic href;
    int cap, n, valid_cnt, we0, tx0;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      exp_q.delete();
      valid_cnt = 0;
      cap = int'($urandom_range(2, 10));
      clear_fifo(cap);
      n = int'($urandom_range(1, 12));
      we0 = we_count;
      send_cmd(8'h01);
      tick(1);
      vsync_pulse();
      for (int i = 0; i < n; i++) begin
        b    = 8'($urandom);
        href = (i == n - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (href) begin
          valid_cnt++;
          if (exp_q.size() < cap) exp_q.push_back(b);
        end
        if (i == n - 1) strobe_with_vsync(b);
        else strobe(b, href);
      end
      tick(3);
      $display("capture %0d: %0d strobes, %0d valid, cap %0d", it, n, valid_cnt, cap);
      cmp_count += 4;
      if (we_count - we0 != exp_q.size()) begin fail_count++; $display("FAIL b2b_we[%0d] got %0d want %0d", it, we_count - we0, exp_q.size()); end
      if (byte_count !== CNT_W'(exp_q.size())) begin fail_count++; $display("FAIL b2b_byte_count[%0d] got %0d want %0d", it, byte_count, exp_q.size()); end
      if (overflow !== (valid_cnt > cap)) begin fail_count++; $display("FAIL b2b_overflow[%0d] got %b want %b", it, overflow, valid_cnt > cap); end
      if (busy !== 1'b0) begin fail_count++; $display("FAIL b2b_busy[%0d] got %b want 0", it, busy); end
      tx0 = tx_log.size();
      send_cmd(8'h02);
      wait_idle(800, ok);
      cmp_count += 2;
      if (!ok) begin fail_count++; $display("FAIL b2b_read_timeout[%0d] got busy=%b want 0", it, busy); end
      if (tx_log.size() - tx0 != exp_q.size()) begin fail_count++; $display("FAIL b2b_read_count[%0d] got %0d want %0d", it, tx_log.size() - tx0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && tx0 + i < tx_log.size(); i++) begin
        cmp_count++;
        if (tx_log[tx0 + i] !== exp_q[i]) begin
          fail_count++;
          $display("FAIL b2b_read_byte[%0d][%0d] got %02h want %02h", it, i, tx_log[tx0 + i], exp_q[i]);
        end
      end
      exp_status = {(valid_cnt > cap), 1'b0, 1'b1, 1'b1, 4'b0000};
      tx0 = tx_log.size();
      send_cmd(8'h03);
      wait_idle(100, ok);
      cmp_count++;
      if (!ok || tx_log.size() != tx0 + 1) begin
        fail_count++;
        $display("FAIL b2b_status_sent[%0d] got %0d bytes want 1", it, tx_log.size() - tx0);
      end else begin
        cmp_count++;
        if (tx_log[tx0] !== exp_status) begin
          fail_count++;
          $display("FAIL b2b_status[%0d] got %02h want %02h", it, tx_log[tx0], exp_status);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    bit found;
    clear_fifo(64);
    @(negedge clk);
    fq.push_back(8'h5A);
    fq.push_back(8'hC3);
    tx_rise_fixed = 10;
    tick(2);
    send_cmd(8'h02);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_start === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    cmp_count += 6;
    if (!found) begin fail_count++; $display("FAIL midop_setup_start got none want 1"); end
    if (busy !== 1'b0) begin fail_count++; $display("FAIL midop_busy got %b want 0", busy); end
    if (tx_data !== '0) begin fail_count++; $display("FAIL midop_tx_data got %02h want 00", tx_data); end
    if (byte_count !== '0) begin fail_count++; $display("FAIL midop_byte_count got %0d want 0", byte_count); end
    if (overflow !== 1'b0) begin fail_count++; $display("FAIL midop_overflow got %b want 0", overflow); end
    if (fifo_re !== 1'b0 || tx_start !== 1'b0) begin
      fail_count++;
      $display("FAIL midop_strobes got re=%b start=%b want 0 0", fifo_re, tx_start);
    end
    reset = 1'b0;
    wait_tx_quiet();
    tx_rise_fixed = -1;
  endtask

  task automatic test_protocol();
    cmp_count += 3;
    if (we_while_full != 0) begin fail_count++; $display("FAIL proto_we_when_full got %0d want 0", we_while_full); end
    if (re_while_empty != 0) begin fail_count++; $display("FAIL proto_re_when_empty got %0d want 0", re_while_empty); end
    if (start_while_busy != 0) begin fail_count++; $display("FAIL proto_start_overlap got %0d want 0", start_while_busy); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow_status();
    test_read();
    test_abort();
    test_back_to_back();
    test_protocol();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
